// File: rtl/branch_resolve_unit_if.sv
// branch_resolve_unit_if: request/result valid-ready bundle for branch_resolve_unit
interface branch_resolve_unit_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int OFF_W  = 13
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_op;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic [ADDR_W-1:0] in_pc;
    logic [OFF_W-1:0]  in_offset;
    logic              in_pred_taken;
    logic              out_valid;
    logic              out_ready;
    logic              out_taken;
    logic [ADDR_W-1:0] out_target;
    logic              out_mispredict;
    logic              out_bad_op;
    modport master (
        output in_valid, in_op, in_a, in_b, in_pc, in_offset, in_pred_taken, out_ready,
        input  in_ready, out_valid, out_taken, out_target, out_mispredict, out_bad_op
    );
    modport slave (
        input  in_valid, in_op, in_a, in_b, in_pc, in_offset, in_pred_taken, out_ready,
        output in_ready, out_valid, out_taken, out_target, out_mispredict, out_bad_op
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: two-stage branch compare/target/mispredict pipe with flush.
// Define BRANCH_STATS_EN to add branch and mispredict counters.
module branch_resolve_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int OFF_W  = 13
) (
    input logic clk,
    input logic reset,
    input logic flush,
    branch_resolve_unit_if.slave bus
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
`endif
);
    typedef struct packed {
        logic [3:0]        op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [ADDR_W-1:0] pc;
        logic [OFF_W-1:0]  off;
        logic              pred;
    } req_t;
    typedef struct packed {
        logic              taken;
        logic [ADDR_W-1:0] target;
        logic              mis;
        logic              bad;
`ifdef BRANCH_STATS_EN
        logic              nz;
`endif
    } res_t;
    logic s1_v_q, s1_v_d, s2_v_q, s2_v_d;
    req_t s1_q, s1_d, in_req;
    res_t s2_q, s2_d, res;
    logic s2_acc, in_fire, eq, lt, bad, cond;
    assign s2_acc       = !s2_v_q || bus.out_ready;
    assign bus.in_ready = reset && !flush && (!s1_v_q || s2_acc);
    assign in_fire      = bus.in_valid && bus.in_ready;
    assign in_req = '{op: bus.in_op, a: bus.in_a, b: bus.in_b, pc: bus.in_pc,
                      off: bus.in_offset, pred: bus.in_pred_taken};
    always_comb begin
        eq   = s1_q.a == s1_q.b;
        lt   = s1_q.op[3] ? $signed(s1_q.a) < $signed(s1_q.b) : s1_q.a < s1_q.b;
        // bit3 only qualifies the ordered compares; EQ/NE/none with bit3 set are illegal
        bad  = &s1_q.op[2:0] || (s1_q.op[3] &&
               (s1_q.op[2:0] == 3'd0 || s1_q.op[2:0] == 3'd1 || s1_q.op[2:0] == 3'd4));
        case (s1_q.op[2:0])
            3'd1:    cond = eq;
            3'd2:    cond = !lt && !eq;
            3'd3:    cond = !lt;
            3'd4:    cond = !eq;
            3'd5:    cond = lt;
            3'd6:    cond = lt || eq;
            default: cond = 1'b0;
        endcase
        res        = '0;
        res.taken  = cond && !bad;
        res.target = s1_q.pc + {{(ADDR_W-OFF_W){s1_q.off[OFF_W-1]}}, s1_q.off};
        res.mis    = res.taken != s1_q.pred;
        res.bad    = bad;
`ifdef BRANCH_STATS_EN
        res.nz     = |s1_q.op;
`endif
        s1_v_d = !flush && (in_fire || (s1_v_q && !s2_acc));
        s1_d   = in_fire ? in_req : s1_q;
        s2_v_d = !flush && (s2_acc ? s1_v_q : s2_v_q);
        s2_d   = (s2_acc && s1_v_q) ? res : s2_q;
    end
    assign bus.out_valid      = s2_v_q;
    assign bus.out_taken      = s2_q.taken;
    assign bus.out_target     = s2_q.target;
    assign bus.out_mispredict = s2_q.mis;
    assign bus.out_bad_op     = s2_q.bad;
`ifdef BRANCH_STATS_EN
    logic [31:0] st_br_q, st_br_d, st_mp_q, st_mp_d;
    logic        cnt;
    always_comb begin
        cnt     = s2_v_q && bus.out_ready && s2_q.nz;
        st_br_d = st_br_q + {31'd0, cnt};
        st_mp_d = st_mp_q + {31'd0, cnt && s2_q.mis};
    end
    assign stat_branches    = st_br_q;
    assign stat_mispredicts = st_mp_q;
`endif
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_v_q <= 1'b0;
            s2_v_q <= 1'b0;
            s1_q   <= '0;
            s2_q   <= '0;
`ifdef BRANCH_STATS_EN
            st_br_q <= '0;
            st_mp_q <= '0;
`endif
        end else begin
            s1_v_q <= s1_v_d;
            s2_v_q <= s2_v_d;
            s1_q   <= s1_d;
            s2_q   <= s2_d;
`ifdef BRANCH_STATS_EN
            st_br_q <= st_br_d;
            st_mp_q <= st_mp_d;
`endif
        end
    end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed vectors for branch_resolve_unit
module tb_branch_resolve_unit;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic flush = 1'b0;
    int n_chk = 0;
    int n_pass = 0;
    always #5 clk = ~clk;
    branch_resolve_unit_if #(.DATA_W(32), .ADDR_W(32), .OFF_W(13)) bus ();
`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches, stat_mispredicts;
`endif
    branch_resolve_unit #(.DATA_W(32), .ADDR_W(32), .OFF_W(13)) dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .bus(bus)
`ifdef BRANCH_STATS_EN
        ,
        .stat_branches(stat_branches),
        .stat_mispredicts(stat_mispredicts)
`endif
    );
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [12:0] off, input logic pred);
        bus.in_valid      = 1'b1;
        bus.in_op         = op;
        bus.in_a          = a;
        bus.in_b          = b;
        bus.in_pc         = pc;
        bus.in_offset     = off;
        bus.in_pred_taken = pred;
    endtask
    task automatic run_one(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] pc, input logic [12:0] off,
                           input logic pred, input logic et, input logic [31:0] etg,
                           input logic em, input logic eb);
        req(op, a, b, pc, off, pred);
        @(negedge clk);
        check({tag, "_in_ready"}, bus.in_ready, 1);
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        check({tag, "_lat1"}, bus.out_valid, 0);
        step();
        @(negedge clk);
        check({tag, "_valid"}, bus.out_valid, 1);
        check({tag, "_taken"}, bus.out_taken, et);
        check({tag, "_target"}, bus.out_target, etg);
        check({tag, "_mis"}, bus.out_mispredict, em);
        check({tag, "_bad"}, bus.out_bad_op, eb);
        step();
    endtask
    initial begin
        bus.in_valid = 0; bus.in_op = 0; bus.in_a = 0; bus.in_b = 0;
        bus.in_pc = 0; bus.in_offset = 0; bus.in_pred_taken = 0; bus.out_ready = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", bus.out_valid, 0);
        check("rst_taken", bus.out_taken, 0);
        check("rst_target", bus.out_target, 0);
        check("rst_mis", bus.out_mispredict, 0);
        check("rst_bad", bus.out_bad_op, 0);
        check("rst_in_ready", bus.in_ready, 0);
        step();
        reset = 1'b1;
        run_one("beq",  4'b0001, 32'd5, 32'd5, 32'h100, 13'd8, 0, 1, 32'h108, 1, 0);
        run_one("blts", 4'b1101, 32'hFFFFFFFF, 32'd1, 32'h200, 13'h1FFC, 1, 1, 32'h1FC, 0, 0);
        run_one("bltu", 4'b0101, 32'hFFFFFFFF, 32'd1, 32'h200, 13'h1FFC, 1, 0, 32'h1FC, 1, 0);
        run_one("wrap", 4'b0100, 32'd1, 32'd2, 32'hFFFFFFF8, 13'd16, 1, 1, 32'h8, 0, 0);
        run_one("op7",  4'b0111, 32'd3, 32'd3, 32'h40, 13'd0, 1, 0, 32'h40, 1, 1);
        run_one("none", 4'b0000, 32'd3, 32'd3, 32'h10, 13'h1000, 0, 0, 32'hFFFFF010, 0, 0);
        run_one("bges", 4'b1011, 32'h80000000, 32'h7FFFFFFF, 32'h0, 13'd2, 0, 0, 32'h2, 0, 0);
        run_one("bgeu", 4'b0011, 32'h80000000, 32'h7FFFFFFF, 32'h0, 13'd2, 0, 1, 32'h2, 1, 0);
        run_one("bles", 4'b1110, 32'd7, 32'd7, 32'h0, 13'd4, 1, 1, 32'h4, 0, 0);
        run_one("bgtu", 4'b0010, 32'd5, 32'd5, 32'h0, 13'd4, 0, 0, 32'h4, 0, 0);
        run_one("op9",  4'b1001, 32'd5, 32'd5, 32'h0, 13'd4, 0, 0, 32'h4, 0, 1);
        // stall: two accepts fill the pipe, then in_ready drops and output holds
        bus.out_ready = 0;
        req(4'b0001, 0, 0, 32'h1000, 0, 0);
        @(negedge clk);
        check("stall_rdy0", bus.in_ready, 1);
        step();
        req(4'b0001, 1, 0, 32'h1010, 0, 0);
        @(negedge clk);
        check("stall_rdy1", bus.in_ready, 1);
        step();
        req(4'b0001, 2, 0, 32'h1020, 0, 0);
        @(negedge clk);
        check("stall_rdy2", bus.in_ready, 0);
        check("stall_valid", bus.out_valid, 1);
        check("stall_tgt0", bus.out_target, 32'h1000);
        repeat (3) begin
            step();
            @(negedge clk);
            check("hold_rdy", bus.in_ready, 0);
            check("hold_tgt", bus.out_target, 32'h1000);
            check("hold_taken", bus.out_taken, 1);
        end
        step();
        bus.out_ready = 1;
        @(negedge clk);
        check("rel_rdy", bus.in_ready, 1);
        step();
        req(4'b0001, 3, 0, 32'h1030, 0, 0);
        @(negedge clk);
        check("drain1_tgt", bus.out_target, 32'h1010);
        check("drain1_taken", bus.out_taken, 0);
        step();
        bus.in_valid = 0;
        @(negedge clk);
        check("drain2_tgt", bus.out_target, 32'h1020);
        check("drain2_valid", bus.out_valid, 1);
        step();
        @(negedge clk);
        check("drain3_tgt", bus.out_target, 32'h1030);
        check("drain3_valid", bus.out_valid, 1);
        step();
        @(negedge clk);
        check("drain_empty", bus.out_valid, 0);
        // flush with both stages full
        bus.out_ready = 0;
        req(4'b0001, 0, 0, 32'h2000, 0, 0);
        step();
        req(4'b0001, 0, 0, 32'h2010, 0, 0);
        step();
        flush = 1;
        req(4'b0001, 0, 0, 32'h2020, 0, 0);
        @(negedge clk);
        check("flush_rdy", bus.in_ready, 0);
        check("flush_pre_valid", bus.out_valid, 1);
        step();
        flush = 0;
        bus.in_valid = 0;
        bus.out_ready = 1;
        @(negedge clk);
        check("flush_valid", bus.out_valid, 0);
        check("flush_rdy_after", bus.in_ready, 1);
        repeat (3) begin
            step();
            @(negedge clk);
            check("flush_quiet", bus.out_valid, 0);
        end
        // reset while a result is stalled discards it
        bus.out_ready = 0;
        step();
        req(4'b0001, 0, 0, 32'h3000, 0, 0);
        step();
        bus.in_valid = 0;
        step();
        @(negedge clk);
        check("rststall_pre", bus.out_valid, 1);
        step();
        reset = 0;
        step();
        @(negedge clk);
        check("rststall_valid", bus.out_valid, 0);
        check("rststall_tgt", bus.out_target, 0);
        check("rststall_rdy", bus.in_ready, 0);
        step();
        reset = 1;
        bus.out_ready = 1;
`ifdef BRANCH_STATS_EN
        run_one("st_beq", 4'b0001, 32'd5, 32'd5, 32'h0, 13'd8, 1, 1, 32'h8, 0, 0);
        run_one("st_bne", 4'b0100, 32'd1, 32'd2, 32'h0, 13'd8, 1, 1, 32'h8, 0, 0);
        run_one("st_blt", 4'b0101, 32'd3, 32'd1, 32'h0, 13'd8, 1, 0, 32'h8, 1, 0);
        run_one("st_none", 4'b0000, 32'd3, 32'd1, 32'h0, 13'd8, 0, 0, 32'h8, 0, 0);
        @(negedge clk);
        check("stat_br", stat_branches, 3);
        check("stat_mp", stat_mispredicts, 1);
        step();
        reset = 0;
        step();
        reset = 1;
        @(negedge clk);
        check("stat_br_rst", stat_branches, 0);
        check("stat_mp_rst", stat_mispredicts, 0);
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
